// File: rtl/demux_reg.sv
// Registered 1-to-OUTPUTS demultiplexer with valid/ready handshake.
// Each output channel owns a 1-entry holding register, so a stalled consumer blocks only its own channel.
module demux_reg #(
    parameter int WIDTH   = 18,
    parameter int OUTPUTS = 4,
    localparam int SEL_W  = $clog2(OUTPUTS)
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic             CE,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0] sel,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready,
    output logic [WIDTH-1:0] out0,
    output logic [WIDTH-1:0] out1,
    output logic [WIDTH-1:0] out2,
    output logic [WIDTH-1:0] out3,
    output logic             err
);

    logic [3:0]       valid_q, valid_d;
    logic [WIDTH-1:0] data_q [4];
    logic [WIDTH-1:0] data_d [4];
    logic             err_q, err_d;

    logic sel_bad;
    logic fire;

    // A select beyond the active channels is accepted unconditionally and then dropped.
    assign sel_bad  = (32'(sel) >= OUTPUTS);
    assign in_ready = RSTN && CE && (sel_bad || !valid_q[sel] || out_ready[sel]);
    assign fire     = in_valid && in_ready;

    always_comb begin
        // NOTE: every variable gets a default before any branch, so no latch can be inferred.
        valid_d = '0;
        err_d   = fire && sel_bad;
        for (int k = 0; k < 4; k++) begin
            data_d[k] = '0;
            if (k < OUTPUTS) begin
                valid_d[k] = valid_q[k] && !out_ready[k];
                data_d[k]  = data_q[k];
                if (fire && !sel_bad && (32'(sel) == k)) begin
                    valid_d[k] = 1'b1;
                    data_d[k]  = in_data;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
        if (!RSTN) begin
            valid_q <= '0;
            err_q   <= 1'b0;
            for (int k = 0; k < 4; k++) data_q[k] <= '0;
        end else begin
            valid_q <= valid_d;
            err_q   <= err_d;
            for (int k = 0; k < 4; k++) data_q[k] <= data_d[k];
        end
    end

    assign out_valid = valid_q;
    assign out0      = data_q[0];
    assign out1      = data_q[1];
    assign out2      = data_q[2];
    assign out3      = data_q[3];
    assign err       = err_q;

endmodule

// File: tb/tb_demux_reg.sv
// Directed bench for demux_reg: a 4-channel instance for routing/handshake and a
// 3-channel instance for the out-of-range select drop.
module tb_demux_reg;

    logic        CLK = 1'b0;
    logic        RSTN, CE, in_valid, in_valid3;
    logic [17:0] in_data;
    logic [1:0]  sel;
    logic [3:0]  out_ready;

    logic        in_ready, err;
    logic [3:0]  out_valid;
    logic [17:0] out0, out1, out2, out3;

    logic        in_ready3, err3;
    logic [3:0]  out_valid3;
    logic [17:0] o3_0, o3_1, o3_2, o3_3;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    demux_reg #(.WIDTH(18), .OUTPUTS(4)) u4 (
        .CLK(CLK), .RSTN(RSTN), .CE(CE), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .sel(sel), .out_valid(out_valid), .out_ready(out_ready),
        .out0(out0), .out1(out1), .out2(out2), .out3(out3), .err(err)
    );

    demux_reg #(.WIDTH(18), .OUTPUTS(3)) u3 (
        .CLK(CLK), .RSTN(RSTN), .CE(CE), .in_valid(in_valid3), .in_ready(in_ready3),
        .in_data(in_data), .sel(sel), .out_valid(out_valid3), .out_ready(out_ready),
        .out0(o3_0), .out1(o3_1), .out2(o3_2), .out3(o3_3), .err(err3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [17:0] out_of(input int i);
        case (i)
            0:       return out0;
            1:       return out1;
            2:       return out2;
            default: return out3;
        endcase
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] s, input logic [17:0] d);
        in_valid = v;
        sel      = s;
        in_data  = d;
    endtask

    logic [17:0] route_data [4];

    initial begin
        route_data[0] = 18'h00011;
        route_data[1] = 18'h00022;
        route_data[2] = 18'h00033;
        route_data[3] = 18'h00044;

        // Reset held two cycles with a word offered
        RSTN = 1'b0; CE = 1'b1; in_valid3 = 1'b0; out_ready = 4'h0;
        drive(1'b1, 2'd0, 18'h00001);
        tick(); tick();
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 4'b0000);
        check("rst_out0", out0, 0);
        check("rst_out1", out1, 0);
        check("rst_out2", out2, 0);
        check("rst_out3", out3, 0);
        check("rst_err", err, 0);
        check("rst_u3_valid", out_valid3, 4'b0000);

        RSTN = 1'b1;
        drive(1'b0, 2'd0, 18'h0);
        tick();

        // Back-to-back routing to every channel
        out_ready = 4'hF;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 2'(i), route_data[i]);
            #1;
            check($sformatf("route_ready_%0d", i), in_ready, 1);
            tick();
            check($sformatf("route_valid_%0d", i), out_valid, 4'b0001 << i);
            check($sformatf("route_data_%0d", i), out_of(i), route_data[i]);
        end
        check("route_err4", err, 0);
        drive(1'b0, 2'd0, 18'h0);
        tick();
        check("route_drained", out_valid, 4'b0000);
        check("route_out0_held", out0, 18'h00011);

        // Backpressure on channel 2
        out_ready = 4'b1011;
        drive(1'b1, 2'd2, 18'h3ABCD);
        #1; check("bp_ready_first", in_ready, 1);
        tick();
        check("bp_valid_first", out_valid, 4'b0100);
        check("bp_out2_first", out2, 18'h3ABCD);
        drive(1'b1, 2'd2, 18'h01234);
        #1; check("bp_ready_blocked", in_ready, 0);
        tick();
        check("bp_valid_stall", out_valid, 4'b0100);
        check("bp_out2_stable", out2, 18'h3ABCD);
        drive(1'b1, 2'd0, 18'h00555);
        #1; check("bp_ready_other", in_ready, 1);
        tick();
        check("bp_valid_other", out_valid, 4'b0101);
        check("bp_out0", out0, 18'h00555);
        out_ready = 4'hF;
        drive(1'b1, 2'd2, 18'h01234);
        #1; check("bp_ready_release", in_ready, 1);
        tick();
        check("bp_valid_release", out_valid, 4'b0100);
        check("bp_out2_second", out2, 18'h01234);
        drive(1'b0, 2'd0, 18'h0);
        tick();
        check("bp_drained", out_valid, 4'b0000);

        // Drain and refill channel 1 in the same cycle
        out_ready = 4'b1101;
        drive(1'b1, 2'd1, 18'h0AAAA);
        tick();
        check("df_valid_load", out_valid, 4'b0010);
        check("df_out1_load", out1, 18'h0AAAA);
        out_ready = 4'hF;
        drive(1'b1, 2'd1, 18'h2FFFF);
        #1; check("df_ready", in_ready, 1);
        tick();
        check("df_valid_kept", out_valid, 4'b0010);
        check("df_out1_new", out1, 18'h2FFFF);
        drive(1'b0, 2'd0, 18'h0);
        tick();
        check("df_drained", out_valid, 4'b0000);

        // CE low: no acceptance, pending channel 3 still drains
        out_ready = 4'b0111;
        drive(1'b1, 2'd3, 18'h00777);
        tick();
        check("ce_valid_load", out_valid, 4'b1000);
        check("ce_out3", out3, 18'h00777);
        CE = 1'b0;
        out_ready = 4'hF;
        drive(1'b1, 2'd0, 18'h00888);
        #1; check("ce_ready_low", in_ready, 0);
        tick();
        check("ce_valid_drained", out_valid, 4'b0000);
        check("ce_out0_untouched", out0, 18'h00555);
        CE = 1'b1;
        drive(1'b0, 2'd3, 18'h3FFFF);

        // Out-of-range select on the 3-channel instance
        in_valid3 = 1'b1;
        #1; check("err_ready", in_ready3, 1);
        tick();
        check("err_pulse", err3, 1);
        check("err_valid", out_valid3, 4'b0000);
        check("err_o3_3_tied", o3_3, 0);
        check("err_u4_quiet", err, 0);
        in_valid3 = 1'b0;
        tick();
        check("err_one_cycle", err3, 0);

        // Reset with channels 0 and 2 stalled
        out_ready = 4'b1010;
        drive(1'b1, 2'd0, 18'h00101);
        tick();
        drive(1'b1, 2'd2, 18'h00202);
        tick();
        check("mr_valid_held", out_valid, 4'b0101);
        RSTN = 1'b0;
        out_ready = 4'hF;
        drive(1'b1, 2'd1, 18'h00303);
        #1; check("mr_ready_rst", in_ready, 0);
        tick();
        check("mr_valid_cleared", out_valid, 4'b0000);
        check("mr_out0", out0, 0);
        check("mr_out1", out1, 0);
        check("mr_out2", out2, 0);
        check("mr_out3", out3, 0);
        RSTN = 1'b1;
        #1; check("mr_ready_resume", in_ready, 1);
        tick();
        check("mr_valid_resume", out_valid, 4'b0010);
        check("mr_out1_resume", out1, 18'h00303);
        drive(1'b0, 2'd0, 18'h0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
